// File: rtl/ucsbece154b_stream_prefetch_if.sv
// Bus bundle between the icache fill port, the stream prefetcher and the SDRAM burst port.
// The prefetcher uses the slave view; the icache/SDRAM side uses the master view.
interface ucsbece154b_stream_prefetch_if;
  logic        ReadRequest;
  logic [31:0] ReadAddress;
  logic [31:0] DataOut;
  logic        DataReady;
  logic        MemReadRequest;
  logic [31:0] MemReadAddress;
  logic [31:0] MemDataIn;
  logic        MemDataReady;

  modport slave (
    input  ReadRequest, ReadAddress, MemDataIn, MemDataReady,
    output DataOut, DataReady, MemReadRequest, MemReadAddress
  );

  modport master (
    output ReadRequest, ReadAddress, MemDataIn, MemDataReady,
    input  DataOut, DataReady, MemReadRequest, MemReadAddress
  );
endinterface

// File: rtl/ucsbece154b_stream_prefetch.sv
// Next-line stream prefetcher between an icache and SDRAM: one-line buffer, one burst in flight.
// Define UCSBECE154B_PREFETCH_STATS_EN to build the saturating HitCount/MissCount counters.
module ucsbece154b_stream_prefetch #(
  parameter int BLOCK_WORDS = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  ucsbece154b_stream_prefetch_if.slave    bus,
  output logic [31:0]                     HitCount,
  output logic [31:0]                     MissCount
);
  localparam int              CW         = $clog2(BLOCK_WORDS);
  localparam int              OFF        = CW + 2;
  localparam logic [31:0]     LINE_BYTES = 32'(4 * BLOCK_WORDS);
  localparam logic [CW-1:0]   LAST       = CW'(BLOCK_WORDS - 1);

  typedef enum logic [2:0] {IDLE, DEMAND, SERVE, PREFETCH, WAIT_PF, DRAIN} state_t;

  state_t                 state_reg;
  logic [31:0]            line_buf [BLOCK_WORDS];
  logic [BLOCK_WORDS-1:0] valid_reg;
  logic [31:0]            tag_reg;
  logic [31:0]            mem_addr_reg;
  logic [31:0]            data_out_reg;
  logic [CW-1:0]          cnt_reg;
  logic [CW-1:0]          cnt_inc;
  logic                   mem_req_reg;
  logic                   data_ready_reg;

  logic [31:0] req_line;
  logic        line_match;
  logic        buf_hit;
  logic        mem_beat;
  logic        burst_done;
  logic        buf_we;
  logic        unused_addr_bits;

  assign req_line         = {bus.ReadAddress[31:OFF], {OFF{1'b0}}};
  assign unused_addr_bits = ^bus.ReadAddress[OFF-1:0];
  assign line_match       = (req_line == tag_reg);
  assign buf_hit          = (&valid_reg) && line_match;
  assign mem_beat         = mem_req_reg && bus.MemDataReady;
  assign burst_done       = mem_beat && (cnt_reg == LAST);
  assign buf_we           = mem_beat && ((state_reg == PREFETCH) || (state_reg == WAIT_PF));
  assign cnt_inc          = cnt_reg + CW'(1);

  // Demand misses stream SDRAM words straight through with no added latency.
  assign bus.DataOut        = (state_reg == DEMAND) ? bus.MemDataIn : data_out_reg;
  assign bus.DataReady      = (state_reg == DEMAND) ? mem_beat : data_ready_reg;
  assign bus.MemReadRequest = mem_req_reg;
  assign bus.MemReadAddress = mem_addr_reg;

  always_ff @(posedge clk) begin
    if (buf_we) begin
      line_buf[cnt_reg] <= bus.MemDataIn;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      valid_reg      <= '0;
      tag_reg        <= '0;
      mem_addr_reg   <= '0;
      data_out_reg   <= '0;
      cnt_reg        <= '0;
      mem_req_reg    <= 1'b0;
      data_ready_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.ReadRequest) begin
            cnt_reg <= '0;
            if (buf_hit) begin
              state_reg      <= SERVE;
              data_ready_reg <= 1'b1;
              data_out_reg   <= line_buf[0];
            end else begin
              state_reg    <= DEMAND;
              mem_req_reg  <= 1'b1;
              mem_addr_reg <= req_line;
            end
          end
        end

        SERVE: begin
          if (cnt_reg == LAST) begin
            state_reg      <= PREFETCH;
            data_ready_reg <= 1'b0;
            tag_reg        <= tag_reg + LINE_BYTES;
            mem_addr_reg   <= tag_reg + LINE_BYTES;
            valid_reg      <= '0;
            cnt_reg        <= '0;
          end else begin
            cnt_reg      <= cnt_inc;
            data_out_reg <= line_buf[cnt_inc];
          end
        end

        DEMAND: begin
          // A low MemReadRequest here is the mandatory idle cycle after a drained burst.
          if (!mem_req_reg) begin
            mem_req_reg <= 1'b1;
          end else if (mem_beat) begin
            cnt_reg <= cnt_inc;
            if (cnt_reg == LAST) begin
              state_reg    <= PREFETCH;
              mem_req_reg  <= 1'b0;
              tag_reg      <= mem_addr_reg + LINE_BYTES;
              mem_addr_reg <= mem_addr_reg + LINE_BYTES;
              valid_reg    <= '0;
              cnt_reg      <= '0;
            end
          end
        end

        PREFETCH, WAIT_PF, DRAIN: begin
          if (!mem_req_reg) begin
            mem_req_reg <= 1'b1;
          end else if (mem_beat) begin
            cnt_reg <= cnt_inc;
            if (state_reg != DRAIN) valid_reg[cnt_reg] <= 1'b1;
            if (burst_done) mem_req_reg <= 1'b0;
          end

          if ((state_reg == PREFETCH) && bus.ReadRequest) begin
            if (line_match) begin
              if (burst_done) begin
                state_reg      <= SERVE;
                data_ready_reg <= 1'b1;
                data_out_reg   <= line_buf[0];
                cnt_reg        <= '0;
              end else begin
                state_reg <= WAIT_PF;
              end
            end else begin
              // Tag now holds the pending demand line; the stale burst is discarded.
              valid_reg <= '0;
              tag_reg   <= req_line;
              if (burst_done) begin
                state_reg    <= DEMAND;
                mem_addr_reg <= req_line;
              end else begin
                state_reg <= DRAIN;
              end
            end
          end else if (burst_done) begin
            if (state_reg == PREFETCH) begin
              state_reg <= IDLE;
            end else if (state_reg == WAIT_PF) begin
              state_reg      <= SERVE;
              data_ready_reg <= 1'b1;
              data_out_reg   <= line_buf[0];
              cnt_reg        <= '0;
            end else begin
              state_reg    <= DEMAND;
              mem_addr_reg <= tag_reg;
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef UCSBECE154B_PREFETCH_STATS_EN
  logic        sampled;
  logic        hit_evt;
  logic        miss_evt;
  logic [31:0] hit_count_reg;
  logic [31:0] miss_count_reg;

  assign sampled  = bus.ReadRequest && ((state_reg == IDLE) || (state_reg == PREFETCH));
  assign hit_evt  = sampled && ((state_reg == IDLE) ? buf_hit : line_match);
  assign miss_evt = sampled && !hit_evt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      if (hit_evt && (hit_count_reg != 32'hFFFF_FFFF))   hit_count_reg  <= hit_count_reg + 32'd1;
      if (miss_evt && (miss_count_reg != 32'hFFFF_FFFF)) miss_count_reg <= miss_count_reg + 32'd1;
    end
  end

  assign HitCount  = hit_count_reg;
  assign MissCount = miss_count_reg;
`else
  assign HitCount  = '0;
  assign MissCount = '0;
`endif
endmodule

// File: doc/ucsbece154b_stream_prefetch.md
UCSBECE154B_STREAM_PREFETCH -- requirements
Module: ucsbece154b_stream_prefetch

Interface
REQ-001 Parameter: BLOCK_WORDS, default 4, words per cache line; power of two, at least 2; line size is 4*BLOCK_WORDS bytes.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ReadRequest  input  1  icache line-fill request; held high with ReadAddress stable until the final DataReady.
REQ-005 ReadAddress  input  32  icache fill byte address; line address = ReadAddress with low log2(BLOCK_WORDS)+2 bits cleared.
REQ-006 DataOut  output  32  returned instruction word.
REQ-007 DataReady  output  1  one-cycle qualifier per DataOut word; words delivered line-aligned, word 0 first.
REQ-008 MemReadRequest  output  1  SDRAM burst request; held high until BLOCK_WORDS MemDataReady pulses received.
REQ-009 MemReadAddress  output  32  line-aligned SDRAM burst address; stable while MemReadRequest is high.
REQ-010 MemDataIn  input  32  SDRAM word, in order word 0..BLOCK_WORDS-1.
REQ-011 MemDataReady  input  1  qualifies MemDataIn.
REQ-012 HitCount  output  32  requests served from the prefetch buffer.
REQ-013 MissCount  output  32  requests forwarded to SDRAM.

Function
REQ-014 States: IDLE, DEMAND, SERVE, PREFETCH, WAIT_PF, DRAIN; buffer = BLOCK_WORDS words, line tag, per-word valid bits.
REQ-015 ReadRequest is sampled only in IDLE or PREFETCH; the requester deasserts it the cycle after its final DataReady.
REQ-016 IDLE, request, buffer fully valid and tag matches line -> SERVE; otherwise -> DEMAND.
REQ-017 SERVE: DataReady high on BLOCK_WORDS consecutive cycles starting the cycle after sampling; DataOut = buffer word k on the k-th cycle; after the last word, the block enters PREFETCH for line+line size.
REQ-018 DEMAND: MemReadRequest asserted from the cycle after sampling with MemReadAddress = demand line; DataOut = MemDataIn and DataReady = MemDataReady combinationally (no added latency); after the last word, the block enters PREFETCH for demand line+line size.
REQ-019 PREFETCH entry clears all valid bits, loads the tag, and holds MemReadRequest low for exactly one cycle before assertion; received words are written into the buffer and set valid; on completion, the block enters IDLE with the buffer fully valid.
REQ-020 PREFETCH, request to the in-flight line -> WAIT_PF; on burst completion -> SERVE; counts as a hit.
REQ-021 PREFETCH, request to any other line -> DRAIN: the burst completes, words are discarded, the buffer is invalidated, then DEMAND with one MemReadRequest-low cycle between bursts.
REQ-022 Address addition wraps modulo 2^32 (0xFFFFFFF0 + 16 -> 0x00000000).
REQ-023 Only one SDRAM burst is outstanding at any time; no burst is aborted.
REQ-024 DataReady is never high in IDLE, PREFETCH, WAIT_PF or DRAIN.
REQ-025 HitCount increments once per request entering SERVE or WAIT_PF; MissCount increments once per request entering DEMAND or DRAIN; both saturate at 0xFFFFFFFF.

Reset
REQ-026 reset high -> state IDLE, valid bits cleared, tag 0, MemReadRequest 0, MemReadAddress 0, DataReady 0, DataOut 0, HitCount 0, MissCount 0, immediately and independent of clk.
REQ-027 reset mid-burst abandons the burst; the SDRAM model is reset on the same signal, so no stale MemDataReady is consumed.

Configuration
REQ-028 Macro UCSBECE154B_PREFETCH_STATS_EN: when defined, HitCount/MissCount behave per REQ-025; when undefined, both outputs are constant 0 and the counter registers are not built; all other behaviour is identical.

Verification
REQ-029 After reset, request 0x00000100 -> MissCount=1; SDRAM burst at 0x100; 4 pass-through words; then a prefetch burst at 0x110 following one MemReadRequest-low cycle.
REQ-030 After the REQ-029 prefetch completes, request 0x00000114 -> no SDRAM request; DataReady on 4 consecutive cycles starting the next cycle with the 0x110 words; HitCount=1; prefetch at 0x120 follows.
REQ-031 Request 0x00000120 while the 0x120 prefetch has 2 of 4 words received -> WAIT_PF; 0 DataReady until the burst ends; then 4 words served; HitCount=2.
REQ-032 Request 0x00000400 during an in-flight 0x130 prefetch -> 0x130 burst completes with no DataReady; then a burst at 0x400 is forwarded; MissCount=2; the buffer tag is not 0x130.
REQ-033 Demand at 0xFFFFFFF0 -> prefetch MemReadAddress=0x00000000; reset asserted on word 2 of that burst -> all outputs 0 in the same cycle; the next request 0x0 misses.
